event_ts_arbiter: RTL and testbench

Shares the free-running wall-clock timestamp among NUM_REQ pixel-group event requesters. Each cycle it grants at most one pending requester round-robin, stamps the event with the current timestamp and requester ID, and presents it on a single-entry valid/ready output toward the event packetizer. It also inserts a timestamp-wrap marker whenever the wall clock rolls over, so downstream logic can extend time beyond TS_WIDTH bits.

---
 rtl/event_ts_arbiter.sv | 119 +++++++++++
 tb/tb_event_ts_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/event_ts_arbiter.sv
// Round-robin arbiter that stamps pixel-group events with the wall-clock timestamp
// and inserts a marker entry whenever the timestamp rolls over.
module event_ts_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int TS_WIDTH = 32,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [TS_WIDTH-1:0] timestamp_i,
  input  logic [NUM_REQ-1:0]  req_i,
  output logic [NUM_REQ-1:0]  ack_o,
  output logic                event_valid_o,
  input  logic                event_ready_i,
  output logic [ID_WIDTH-1:0] event_id_o,
  output logic [TS_WIDTH-1:0] event_ts_o,
  output logic                event_wrap_o
);

  localparam int unsigned NREQ = NUM_REQ;

  typedef enum logic {
    EMPTY,
    FULL
  } state_e;

  state_e              state_q, state_d;
  logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic                msb_q, msb_d;
  logic                wrap_pend_q, wrap_pend_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic                wrap_q, wrap_d;

  logic                load_ok;
  logic                wrap_det;
  logic                found;
  logic [ID_WIDTH-1:0] grant_idx;
  logic [ID_WIDTH-1:0] scan_idx;
  logic                load_wrap;
  logic                load_pix;
  logic                load;

  // Rotating priority search starting at rr_ptr_q.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      scan_idx = ID_WIDTH'((32'(rr_ptr_q) + i) % NREQ);
      if (!found && req_i[scan_idx]) begin
        found     = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    ts_d        = ts_q;
    wrap_d      = wrap_q;
    ack_o       = '0;

    // Gating with reset_i keeps ack_o silent while reset is held.
    load_ok   = reset_i & ((state_q == EMPTY) | event_ready_i);
    wrap_det  = msb_q & ~timestamp_i[TS_WIDTH-1];
    load_wrap = load_ok & wrap_pend_q;
    load_pix  = load_ok & ~wrap_pend_q & found;
    load      = load_wrap | load_pix;

    msb_d       = timestamp_i[TS_WIDTH-1];
    wrap_pend_d = (wrap_pend_q & ~load_wrap) | wrap_det;

    if (load_pix) begin
      ack_o[grant_idx] = 1'b1;
      rr_ptr_d         = ID_WIDTH'((32'(grant_idx) + 32'd1) % NREQ);
    end

    if (load) begin
      id_d   = load_wrap ? '0 : grant_idx;
      ts_d   = timestamp_i;
      wrap_d = load_wrap;
    end

    case (state_q)
      EMPTY:   if (load) state_d = FULL;
      FULL:    if (event_ready_i && !load) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= EMPTY;
      rr_ptr_q    <= '0;
      msb_q       <= 1'b0;
      wrap_pend_q <= 1'b0;
      id_q        <= '0;
      ts_q        <= '0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      msb_q       <= msb_d;
      wrap_pend_q <= wrap_pend_d;
      id_q        <= id_d;
      ts_q        <= ts_d;
      wrap_q      <= wrap_d;
    end
  end

  assign event_valid_o = (state_q == FULL);
  assign event_id_o    = id_q;
  assign event_ts_o    = ts_q;
  assign event_wrap_o  = wrap_q;

endmodule

// File: tb/tb_event_ts_arbiter.sv
// Directed bench for event_ts_arbiter: reset, single grant, round-robin,
// backpressure and timestamp-wrap markers (free and under stall).
module tb_event_ts_arbiter;

  logic        clk_i;
  logic        reset_i;
  logic [31:0] timestamp_i;
  logic [3:0]  req_i;
  logic [3:0]  ack_o;
  logic        event_valid_o;
  logic        event_ready_i;
  logic [1:0]  event_id_o;
  logic [31:0] event_ts_o;
  logic        event_wrap_o;

  int checks = 0;
  int errors = 0;

  event_ts_arbiter #(
    .NUM_REQ (4),
    .TS_WIDTH(32)
  ) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .timestamp_i  (timestamp_i),
    .req_i        (req_i),
    .ack_o        (ack_o),
    .event_valid_o(event_valid_o),
    .event_ready_i(event_ready_i),
    .event_id_o   (event_id_o),
    .event_ts_o   (event_ts_o),
    .event_wrap_o (event_wrap_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge; the wall clock advances just after it.
  task automatic tick();
    @(posedge clk_i);
    #1;
    timestamp_i = timestamp_i + 32'd1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_entry(input string tag, input logic v, input logic [1:0] id,
                           input logic [31:0] ts, input logic w);
    chk({tag, "_valid"}, 64'(event_valid_o), 64'(v));
    chk({tag, "_id"},    64'(event_id_o),    64'(id));
    chk({tag, "_ts"},    64'(event_ts_o),    64'(ts));
    chk({tag, "_wrap"},  64'(event_wrap_o),  64'(w));
  endtask

  logic [31:0] t0;
  logic [31:0] tb;
  logic [31:0] wexp_ts   [6];
  logic        wexp_wrap [6];
  logic [3:0]  wexp_ack  [6];

  initial begin
    reset_i       = 1'b0;
    timestamp_i   = '0;
    req_i         = '0;
    event_ready_i = 1'b0;

    // Reset state
    tick(); tick(); settle();
    chk_entry("rst", 1'b0, 2'd0, 32'h0, 1'b0);
    chk("rst_ack", 64'(ack_o), 64'h0);
    reset_i = 1'b1;

    // Single request: ack same cycle, entry next cycle
    timestamp_i = 32'h10;
    req_i       = 4'b0100;
    settle();
    chk("single_ack", 64'(ack_o), 64'b0100);
    tick();
    req_i = 4'b0000;
    settle();
    chk_entry("single", 1'b1, 2'd2, 32'h10, 1'b0);
    chk("single_ack_after", 64'(ack_o), 64'h0);

    // Reset while FULL and stalled: everything clears at once
    reset_i = 1'b0;
    settle();
    chk_entry("rst_full", 1'b0, 2'd0, 32'h0, 1'b0);
    req_i = 4'b1111;
    settle();
    chk("rst_ack_held", 64'(ack_o), 64'h0);
    reset_i       = 1'b1;
    event_ready_i = 1'b1;
    settle();
    t0 = timestamp_i;

    // Round-robin over all requesters
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rr_ack%0d", i), 64'(ack_o), 64'(4'b0001 << (i % 4)));
      tick();
      settle();
      chk($sformatf("rr_id%0d", i), 64'(event_id_o), 64'(i % 4));
      chk($sformatf("rr_ts%0d", i), 64'(event_ts_o), 64'(t0 + 32'(i)));
    end

    // Backpressure: entry held, no acks
    event_ready_i = 1'b0;
    req_i         = 4'b0011;
    settle();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_ack%0d", i), 64'(ack_o), 64'h0);
      chk_entry($sformatf("bp%0d", i), 1'b1, 2'd0, t0 + 32'd4, 1'b0);
      tick();
      settle();
    end
    event_ready_i = 1'b1;
    settle();
    chk("drain_ack0", 64'(ack_o), 64'b0010);
    tb = timestamp_i;
    tick();
    req_i = 4'b0001;
    settle();
    chk_entry("drain0", 1'b1, 2'd1, tb, 1'b0);
    chk("drain_ack1", 64'(ack_o), 64'b0001);
    tick();
    req_i = 4'b0000;
    settle();
    chk_entry("drain1", 1'b1, 2'd0, tb + 32'd1, 1'b0);
    chk("drain_ack2", 64'(ack_o), 64'h0);
    tick();
    settle();
    chk("drain_empty", 64'(event_valid_o), 64'h0);

    // Rollover with a requester held: exactly one marker, ts=1
    wexp_ts   = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'h2, 32'h3};
    wexp_wrap = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    wexp_ack  = '{4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0001};
    timestamp_i = 32'hFFFF_FFFD;
    tick();
    req_i = 4'b0001;
    settle();
    chk("wrap_ack_pre", 64'(ack_o), 64'b0001);
    for (int i = 0; i < 6; i++) begin
      tick();
      settle();
      chk_entry($sformatf("wrap%0d", i), 1'b1, 2'd0, wexp_ts[i], wexp_wrap[i]);
      chk($sformatf("wrap_ack%0d", i), 64'(ack_o), 64'(wexp_ack[i]));
    end
    req_i = 4'b0000;
    tick();
    tick();
    settle();
    chk("wrap_empty", 64'(event_valid_o), 64'h0);

    // Rollover under stall: marker precedes the waiting pixel event
    timestamp_i   = 32'hFFFF_FFFE;
    event_ready_i = 1'b0;
    req_i         = 4'b0010;
    settle();
    chk("stall_ack0", 64'(ack_o), 64'b0010);
    tick();
    req_i = 4'b0100;
    settle();
    chk("stall_ack1", 64'(ack_o), 64'h0);
    chk_entry("stall_hold", 1'b1, 2'd1, 32'hFFFF_FFFE, 1'b0);
    tick();
    tick();
    tick();
    event_ready_i = 1'b1;
    settle();
    chk("stall_ack_marker", 64'(ack_o), 64'h0);
    tick();
    settle();
    chk_entry("stall_marker", 1'b1, 2'd0, 32'h2, 1'b1);
    chk("stall_ack_pix", 64'(ack_o), 64'b0100);
    tick();
    req_i = 4'b0000;
    settle();
    chk_entry("stall_pix", 1'b1, 2'd2, 32'h3, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
